// File: rtl/oled_send_arbiter.sv
// Round-robin, burst-granular arbiter sharing one OLED byte channel among NUM_REQ text sources.
// Optional per-byte send_done watchdog enabled by defining OLED_ARB_TIMEOUT_EN.
module oled_send_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 2**20
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             send_data,
    output logic                   send_data_valid,
    input  logic                   send_done,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]         state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      owner;
    logic               last_q;

    logic               win_found;
    logic [IW-1:0]      win_idx;
    logic [IW:0]        scan;

    logic               accept;
    logic [IW-1:0]      acc_idx;
    logic [7:0]         acc_byte;
    logic               acc_last;
    logic [NUM_REQ-1:0] acc_onehot;
    logic [IW-1:0]      next_ptr;

    // First valid requester scanning ptr, ptr+1, ... with wrap at NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr} + (IW+1)'(k);
            if (scan >= (IW+1)'(NUM_REQ)) begin
                scan = scan - (IW+1)'(NUM_REQ);
            end
            if (!win_found && req_valid[scan[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[IW-1:0];
            end
        end
    end

    always_comb begin
        accept  = 1'b0;
        acc_idx = win_idx;
        if (!send_done) begin
            if (state == ST_IDLE) begin
                accept = win_found;
            end else if (state == ST_WAIT) begin
                accept  = req_valid[owner];
                acc_idx = owner;
            end
        end
        acc_byte = '0;
        acc_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_idx == IW'(i)) begin
                acc_byte = req_data[8*i +: 8];
                acc_last = req_last[i];
            end
        end
    end

    assign acc_onehot = NUM_REQ'(1) << acc_idx;
    assign next_ptr   = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
    // Gated by reset_n so no acceptance is signalled while the arbiter is held in reset.
    assign req_ready  = (accept && reset_n) ? acc_onehot : '0;
    assign busy       = |grant;

`ifdef OLED_ARB_TIMEOUT_EN
    logic [31:0] cnt;
    logic        err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            ptr             <= '0;
            owner           <= '0;
            last_q          <= 1'b0;
            grant           <= '0;
            send_data       <= '0;
            send_data_valid <= 1'b0;
            cnt             <= '0;
            err_q           <= 1'b0;
        end else if (accept) begin
            state           <= ST_SEND;
            owner           <= acc_idx;
            grant           <= acc_onehot;
            send_data       <= acc_byte;
            last_q          <= acc_last;
            send_data_valid <= 1'b1;
            cnt             <= '0;
        end else if (state == ST_SEND) begin
            if (send_done) begin
                send_data_valid <= 1'b0;
                if (last_q) begin
                    grant <= '0;
                    ptr   <= next_ptr;
                    state <= ST_IDLE;
                end else begin
                    state <= ST_WAIT;
                end
            end else if (cnt == TIMEOUT - 32'd1) begin
                // Abandon the burst; the flag stays set until reset.
                send_data_valid <= 1'b0;
                grant           <= '0;
                ptr             <= next_ptr;
                err_q           <= 1'b1;
                state           <= ST_IDLE;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

    assign timeout_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            ptr             <= '0;
            owner           <= '0;
            last_q          <= 1'b0;
            grant           <= '0;
            send_data       <= '0;
            send_data_valid <= 1'b0;
        end else if (accept) begin
            state           <= ST_SEND;
            owner           <= acc_idx;
            grant           <= acc_onehot;
            send_data       <= acc_byte;
            last_q          <= acc_last;
            send_data_valid <= 1'b1;
        end else if (state == ST_SEND) begin
            if (send_done) begin
                send_data_valid <= 1'b0;
                if (last_q) begin
                    grant <= '0;
                    ptr   <= next_ptr;
                    state <= ST_IDLE;
                end else begin
                    state <= ST_WAIT;
                end
            end
        end
    end

    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_oled_send_arbiter.sv
// Randomized bench for oled_send_arbiter with a queue-based channel-ownership model.
// Define OLED_ARB_TIMEOUT_EN for both bench and design to exercise the watchdog with TIMEOUT=100.
module tb_oled_send_arbiter;

    localparam int N = 3;
`ifdef OLED_ARB_TIMEOUT_EN
    localparam int unsigned TO = 100;
`else
    localparam int unsigned TO = 2**20;
`endif

    logic           clock = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic [7:0]     send_data;
    logic           send_data_valid, send_done, busy, timeout_err;

    oled_send_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .grant           (grant),
        .send_data       (send_data),
        .send_data_valid (send_data_valid),
        .send_done       (send_done),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 clock = ~clock;

    int n_checks, n_fail;

    // Requester side: queued {last, byte} entries, presented one at a time.
    logic [8:0] bq [N][$];
    bit         presenting [N];
    logic [8:0] cur [N];
    int         wcnt [N];
    int         rdy_cnt [N];
    int         pres_pct, dmin, dmax, hmin, hmax, gmin, gmax;
    bit         no_ack;
    int         hold, dly;

    // Channel model: who owns it, whether a byte is outstanding, next priority.
    int         m_owner, m_ptr, m_cnt;
    bit         m_valid, m_last, m_err;
    logic [7:0] m_data;

    logic [N+7:0] log_q [$];
    bit           prev_v;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_owner = -1; m_ptr = 0; m_cnt = 0;
        m_valid = 0; m_last = 0; m_err = 0; m_data = '0;
        for (int i = 0; i < N; i++) begin
            presenting[i] = 0; cur[i] = '0; wcnt[i] = 0; rdy_cnt[i] = 0;
            bq[i].delete();
        end
        hold = 0; dly = 0; prev_v = 0;
        log_q.delete();
    endtask

    function automatic bit activity();
        bit a;
        a = m_valid || (m_owner >= 0) || (hold > 0);
        for (int i = 0; i < N; i++) a = a || presenting[i] || (bq[i].size() > 0);
        return a;
    endfunction

    task automatic cycle();
        int sel;
        logic [N-1:0] er, eg;
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            if (!presenting[i] && bq[i].size() > 0) begin
                if (wcnt[i] > 0) wcnt[i]--;
                else if (int'($urandom_range(99)) < pres_pct) begin
                    presenting[i] = 1;
                    cur[i] = bq[i].pop_front();
                end
            end
            req_valid[i]        = presenting[i];
            req_last[i]         = presenting[i] ? cur[i][8] : 1'($urandom);
            req_data[i*8 +: 8]  = presenting[i] ? cur[i][7:0] : 8'($urandom);
        end
        if (hold > 0) begin
            send_done = 1; hold--;
        end else if (m_valid && !no_ack && dly == 0) begin
            send_done = 1; hold = int'($urandom_range(hmax, hmin)) - 1;
        end else begin
            send_done = 0;
            if (m_valid && !no_ack) dly--;
        end
        #1;
        // Expected acceptance: only with no byte outstanding and send_done low.
        sel = -1;
        if (!send_done && !m_valid) begin
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (sel < 0 && req_valid[j]) sel = j;
                end
            end else if (req_valid[m_owner]) begin
                sel = m_owner;
            end
        end
        er = (sel >= 0) ? (N'(1) << sel) : '0;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("grant", 32'(grant), 32'(eg));
        chk("send_data", 32'(send_data), 32'(m_data));
        chk("send_data_valid", 32'(send_data_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
        if (send_data_valid && !prev_v) log_q.push_back({grant, send_data});
        prev_v = send_data_valid;
        for (int i = 0; i < N; i++) if (req_ready[i]) rdy_cnt[i]++;
        if (sel >= 0) begin
            m_owner = sel; m_data = cur[sel][7:0]; m_last = cur[sel][8];
            m_valid = 1; m_cnt = 0;
            presenting[sel] = 0;
            wcnt[sel] = int'($urandom_range(gmax, gmin));
            dly = int'($urandom_range(dmax, dmin));
        end else if (m_valid) begin
            if (send_done) begin
                m_valid = 0;
                if (m_last) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
            end
`ifdef OLED_ARB_TIMEOUT_EN
            else if (m_cnt == int'(TO) - 1) begin
                m_valid = 0; m_ptr = (m_owner + 1) % N; m_owner = -1; m_err = 1;
            end else begin
                m_cnt++;
            end
`endif
        end
    endtask

    task automatic run_until_idle(input string nm, input int maxc);
        int c;
        c = 0;
        while (activity() && c < maxc) begin cycle(); c++; end
        n_checks++;
        if (c >= maxc) begin
            n_fail++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", nm, maxc);
        end
        repeat (2) cycle();
    endtask

    task automatic do_reset();
        reset_n = 0; req_valid = '0; send_done = 0;
        model_clear();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1;
    endtask

    task automatic push_burst(input int r, input int len, input logic [7:0] base);
        for (int b = 0; b < len; b++) bq[r].push_back({(b == len - 1), base + 8'(b)});
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        pres_pct = 100; dmin = 0; dmax = 0; hmin = 1; hmax = 1; gmin = 0; gmax = 0; no_ack = 0;
        reset_n = 0; req_valid = '0; req_data = '0; req_last = '0; send_done = 0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", 32'(send_data_valid), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_data", 32'(send_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(timeout_err), 0);
        @(negedge clock);
        reset_n = 1;

        // Single burst "HI", acknowledged 20 cycles after each issue.
        dmin = 20; dmax = 20;
        bq[0].push_back(9'h048);
        bq[0].push_back(9'h149);
        run_until_idle("t2_idle", 200);
        chk("t2_count", 32'(log_q.size()), 2);
        chk("t2_byte0", 32'(log_q[0]), 32'({3'b001, 8'h48}));
        chk("t2_byte1", 32'(log_q[1]), 32'({3'b001, 8'h49}));
        chk("t2_ready_pulses", 32'(rdy_cnt[0]), 2);
        chk("t2_grant_after", 32'(grant), 0);

        // Contention from ptr=0, then again after req1's burst.
        do_reset();
        dmin = 0; dmax = 3; hmin = 1; hmax = 2;
        push_burst(0, 3, 8'h10);
        push_burst(1, 3, 8'h20);
        run_until_idle("t3a_idle", 300);
        push_burst(0, 1, 8'h30);
        push_burst(1, 1, 8'h40);
        run_until_idle("t3b_idle", 300);
        chk("t3_first_owner", 32'(log_q[0][N+7:8]), 32'(3'b001));
        chk("t3_req0_end", 32'(log_q[2]), 32'({3'b001, 8'h12}));
        chk("t3_req1_start", 32'(log_q[3]), 32'({3'b010, 8'h20}));
        chk("t3_second_round", 32'(log_q[6]), 32'({3'b001, 8'h30}));
        chk("t3_second_round_b", 32'(log_q[7]), 32'({3'b010, 8'h40}));

        // req1 arrives during req0's 10-cycle inter-byte gap and must wait.
        log_q.delete();
        gmin = 10; gmax = 10; dmin = 2; dmax = 2; hmin = 1; hmax = 1;
        push_burst(0, 2, 8'hA0);
        repeat (3) cycle();
        push_burst(1, 1, 8'hB0);
        run_until_idle("t4_idle", 200);
        chk("t4_count", 32'(log_q.size()), 3);
        chk("t4_byte1", 32'(log_q[1]), 32'({3'b001, 8'hA1}));
        chk("t4_byte2", 32'(log_q[2]), 32'({3'b010, 8'hB0}));

        // send_done held high for 5 cycles after each ack.
        log_q.delete();
        gmin = 0; gmax = 0; dmin = 1; dmax = 1; hmin = 5; hmax = 5;
        push_burst(2, 2, 8'hC0);
        run_until_idle("t5_idle", 200);
        chk("t5_count", 32'(log_q.size()), 2);
        chk("t5_byte1", 32'(log_q[1]), 32'({3'b100, 8'hC1}));

        // Random traffic.
        pres_pct = 60; dmin = 0; dmax = 6; hmin = 1; hmax = 4; gmin = 0; gmax = 3;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (bq[i].size() == 0 && !presenting[i] && $urandom_range(19) == 0)
                    push_burst(i, int'($urandom_range(4, 1)), 8'($urandom));
            end
            cycle();
        end
        run_until_idle("rand_idle", 500);

        // Downstream never acknowledges.
        no_ack = 1; pres_pct = 100; gmin = 0; gmax = 0;
        bq[1].push_back(9'h155);
        repeat (1000) cycle();
`ifdef OLED_ARB_TIMEOUT_EN
        chk("t6_err", 32'(timeout_err), 1);
        chk("t6_valid", 32'(send_data_valid), 0);
        chk("t6_grant", 32'(grant), 0);
`else
        chk("t6_valid", 32'(send_data_valid), 1);
        chk("t6_grant", 32'(grant), 32'(3'b010));
`endif

        // Asynchronous reset mid-byte.
        bq[0].push_back(9'h1AA);
        repeat (5) cycle();
        chk("t1_pre_valid", 32'(send_data_valid), 1);
        reset_n = 0;
        #1;
        chk("t1_valid", 32'(send_data_valid), 0);
        chk("t1_grant", 32'(grant), 0);
        chk("t1_ready", 32'(req_ready), 0);
        chk("t1_err", 32'(timeout_err), 0);
        model_clear();
        no_ack = 0;
        req_valid = '0;
        @(negedge clock);
        reset_n = 1;
        repeat (5) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
